// File: rtl/seq_pkg.sv
// seq_pkg: frame states and sync pattern shared by the seq_tx transmitter and its detector.
package seq_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, PAYLOAD, PARITY, DONE} seq_state_e;
  localparam logic [4:0] SYNC_PATTERN = 5'b10110;
  localparam int SYNC_LEN = 5;
  function automatic logic sync_bit(input logic [2:0] i);
    return SYNC_PATTERN[3'(SYNC_LEN - 1) - i];
  endfunction
endpackage

// File: rtl/seq_tx_shreg.sv
// seq_tx_shreg: payload load/shift-left register with MSB out and running parity (SEQ_TX_PARITY_EN).
module seq_tx_shreg
  import seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
`ifdef SEQ_TX_PARITY_EN
  output logic         par_o,
`endif
  output logic         msb_o
);
  logic [W-1:0] sh_q;
  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else if (load_i) sh_q <= data_i;
    else if (shift_i) sh_q <= sh_q << 1;
  end
  assign msb_o = sh_q[W-1];
`ifdef SEQ_TX_PARITY_EN
  // every payload bit passes through the MSB exactly once, so this ends as XOR of the payload
  logic par_q;
  always_ff @(posedge clk) begin
    if (rst || load_i) par_q <= 1'b0;
    else if (shift_i) par_q <= par_q ^ sh_q[W-1];
  end
  assign par_o = par_q;
`endif
endmodule

// File: rtl/seq_tx.sv
// seq_tx: serial frame transmitter (sync 10110, W-bit payload MSB-first, even parity with SEQ_TX_PARITY_EN).
module seq_tx
  import seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data,
  output logic         o,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(W > SYNC_LEN ? W : SYNC_LEN);
  seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic o_q, o_d, busy_q, busy_d, done_q, done_d;
  logic load, shift, msb;
`ifdef SEQ_TX_PARITY_EN
  logic par;
`endif
  seq_tx_shreg #(.W(W)) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .shift_i(shift),
    .data_i (data),
`ifdef SEQ_TX_PARITY_EN
    .par_o  (par),
`endif
    .msb_o  (msb)
  );
  // o_d is the line value for the cycle after this edge, so the line is a pure register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SYNC;
        cnt_d   = '0;
        load    = 1'b1;
        o_d     = sync_bit(3'd0);
      end
      SYNC: if (cnt_q == CW'(SYNC_LEN - 1)) begin
        state_d = PAYLOAD;
        cnt_d   = '0;
        o_d     = msb;
        shift   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        o_d   = sync_bit(3'(cnt_q) + 3'd1);
      end
      PAYLOAD: if (cnt_q == CW'(W - 1)) begin
`ifdef SEQ_TX_PARITY_EN
        state_d = PARITY;
        o_d     = par;
`else
        state_d = DONE;
        done_d  = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + CW'(1);
        o_d   = msb;
        shift = 1'b1;
      end
`ifdef SEQ_TX_PARITY_EN
      PARITY: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign o    = o_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
